// File: rtl/vita2000_pkg.sv
// Shared types for the VITA2000 write burster: FIFO entry layout, FSM states
// and the address-discontinuity rule.
package vita2000_pkg;

    localparam int VITA_ADDR_W = 19;
    localparam int VITA_DATA_W = 64;

    typedef struct packed {
        logic                   brk;
        logic [VITA_ADDR_W-1:0] addr;
        logic [VITA_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_BURST = 1'b1
    } wb_state_t;

    // Address 0 is always a frame start, so the 0x7FFFF->0 wrap never counts as contiguous.
    function automatic logic addr_break(input logic [VITA_ADDR_W-1:0] addr,
                                        input logic [VITA_ADDR_W-1:0] last_addr,
                                        input logic                   last_vld);
        return (addr == '0) || !last_vld || (addr != last_addr + VITA_ADDR_W'(1));
    endfunction

endpackage

// File: rtl/vita2000_write_fifo.sv
// Show-ahead FIFO of wb_entry_t: exposes the head entry and the one behind it,
// and accepts a push while full if the head is popped in the same cycle.
module vita2000_write_fifo
    import vita2000_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  wb_entry_t                entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output wb_entry_t                next_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + AW'(1)];
    assign level_o = level_q;

endmodule

// File: rtl/vita2000_write_burster.sv
// Buffers the capture word stream and emits address-contiguous write bursts
// on a valid/ready sink. Optional FRAME_STATS_EN adds frame/drop counters.
module vita2000_write_burster
    import vita2000_pkg::*;
#(
    parameter int BURST_LEN    = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int FLUSH_CYCLES = 256
) (
    input  logic                          pclock,
    input  logic                          reset_n,
    input  logic [VITA_ADDR_W-1:0]        w_addr,
    input  logic [VITA_DATA_W-1:0]        w_data,
    input  logic                          we,
    output logic [VITA_ADDR_W-1:0]        mem_addr,
    output logic [VITA_DATA_W-1:0]        mem_data,
    output logic                          mem_first,
    output logic                          mem_last,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   drop_count
`endif
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int IDLE_W = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FLUSH_CYCLES - 1);

    logic [1:0]              rst_sync_q;
    logic                    rst_n_s;

    wb_state_t               state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    flush_q, flush_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [VITA_ADDR_W-1:0]  last_addr_q;
    logic                    last_vld_q;
    logic                    overflow_q;
    logic                    hold_q, hold_last_q;

    wb_entry_t               new_entry, fifo_head, fifo_next;
    logic [LVL_W-1:0]        fifo_lvl;
    logic                    fifo_full;
    logic                    push_ok, drop, pop;
    logic                    valid_c, last_raw, last_c;
    logic                    lvl_ge2, lvl_one;
    logic                    unused_fields;

    // Reset asserts asynchronously but releases on a pclock edge.
    always_ff @(posedge pclock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_q[1];

    assign push_ok = we && (!fifo_full || pop);
    assign drop    = we && !push_ok;

    always_comb begin
        new_entry.brk  = addr_break(w_addr, last_addr_q, last_vld_q);
        new_entry.addr = w_addr;
        new_entry.data = w_data;
    end

    vita2000_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (pclock),
        .rst_ni  (rst_n_s),
        .push_i  (push_ok),
        .entry_i (new_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .level_o (fifo_lvl),
        .full_o  (fifo_full)
    );

    assign lvl_ge2 = (fifo_lvl >= LVL_W'(2));
    assign lvl_one = (fifo_lvl == LVL_W'(1));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        flush_d  = flush_q;
        valid_c  = 1'b0;
        last_raw = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (fifo_lvl >= LVL_BURST) begin
                    state_d = WB_BURST;
                    flush_d = 1'b0;
                    beat_d  = '0;
                end else if ((fifo_lvl != '0) && (idle_q == IDLE_MAX)) begin
                    state_d = WB_BURST;
                    flush_d = 1'b1;
                    beat_d  = '0;
                end
            end
            WB_BURST: begin
                valid_c  = lvl_ge2 || (lvl_one && (flush_q || (beat_q == BEAT_MAX)));
                last_raw = (beat_q == BEAT_MAX) || (lvl_ge2 && fifo_next.brk)
                           || (lvl_one && flush_q);
                // A stalled flush beat could see a new push flip last; keep what the sink saw.
                last_c   = hold_q ? hold_last_q : last_raw;
                if (valid_c && mem_ready) begin
                    if (last_c) begin
                        state_d = WB_IDLE;
                        beat_d  = '0;
                        flush_d = 1'b0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign pop = valid_c && mem_ready;

    always_comb begin
        idle_d = idle_q;
        if (we || (fifo_lvl == '0)) begin
            idle_d = '0;
        end else if ((state_q == WB_IDLE) && (state_d == WB_IDLE) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge pclock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= WB_IDLE;
            beat_q      <= '0;
            flush_q     <= 1'b0;
            idle_q      <= '0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
            hold_q      <= 1'b0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            idle_q      <= idle_d;
            hold_q      <= valid_c && !mem_ready;
            hold_last_q <= last_c;
            if (push_ok) begin
                last_addr_q <= w_addr;
                last_vld_q  <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0] frame_q, drop_q;

    always_ff @(posedge pclock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push_ok && (w_addr == '0) && (frame_q != 16'hFFFF)) begin
                frame_q <= frame_q + 16'd1;
            end
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_q;
    assign drop_count  = drop_q;
`endif

    assign mem_valid  = valid_c;
    assign mem_first  = valid_c && (beat_q == '0);
    assign mem_last   = valid_c && last_c;
    assign mem_addr   = valid_c ? fifo_head.addr : '0;
    assign mem_data   = valid_c ? fifo_head.data : '0;
    assign overflow   = overflow_q;
    assign fifo_level = fifo_lvl;

    assign unused_fields = ^{fifo_head.brk, fifo_next.addr, fifo_next.data};

endmodule
